// File: rtl/ysyx_2022040010_wb_arbiter.sv
// rtl/ysyx_2022040010_wb_arbiter.sv - register-file writeback arbiter: loads, buffered execute results, busy vector
module ysyx_2022040010_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wen,
  input  logic [4:0]  ex_rd,
  input  logic [63:0] ex_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [63:0] ld_data,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [2:0]  ld_offset,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [63:0] wdata,
  output logic [31:0] busy
);

  localparam logic [1:0] Depth = 2'(FIFO_DEPTH);

  logic [1:0]  count_q, count_d;
  logic [4:0]  f0_rd_q, f0_rd_d, f1_rd_q, f1_rd_d;
  logic [63:0] f0_data_q, f0_data_d, f1_data_q, f1_data_d;
  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] sb_q, sb_d;

  logic        ex_fire, ex_keep, pop, push, win;
  logic [4:0]  win_rd;
  logic [63:0] win_data;
  logic [1:0]  cnt_after;
  logic [5:0]  shamt;
  logic [63:0] shifted, ld_ext;
  logic [31:0] busy_c;

  assign ex_ready = !rst && (count_q < Depth);

  // Doubleword accesses are always aligned, so the offset is ignored for them.
  always_comb begin
    shamt   = (ld_size == 2'd3) ? 6'd0 : {ld_offset, 3'b000};
    shifted = ld_data >> shamt;
    ld_ext  = shifted;
    case (ld_size)
      2'd0:    ld_ext = {{56{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_ext = {{48{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      2'd2:    ld_ext = {{32{~ld_unsigned & shifted[31]}}, shifted[31:0]};
      default: ld_ext = shifted;
    endcase
  end

  always_comb begin
    ex_fire  = ex_valid && ex_ready;
    ex_keep  = ex_fire && ex_wen && (ex_rd != 5'd0);
    pop      = 1'b0;
    push     = 1'b0;
    win      = 1'b0;
    win_rd   = 5'd0;
    win_data = 64'd0;
    if (ld_valid) begin
      win      = 1'b1;
      win_rd   = ld_rd;
      win_data = ld_ext;
      push     = ex_keep;
    end else if (count_q != 2'd0) begin
      win      = 1'b1;
      win_rd   = f0_rd_q;
      win_data = f0_data_q;
      pop      = 1'b1;
      push     = ex_keep;
    end else if (ex_keep) begin
      win      = 1'b1;
      win_rd   = ex_rd;
      win_data = ex_data;
    end

    // Shift-register FIFO: entry 0 is always the head.
    f0_rd_d   = pop ? f1_rd_q : f0_rd_q;
    f0_data_d = pop ? f1_data_q : f0_data_q;
    f1_rd_d   = f1_rd_q;
    f1_data_d = f1_data_q;
    cnt_after = count_q - {1'b0, pop};
    if (push) begin
      if (cnt_after == 2'd0) begin
        f0_rd_d   = ex_rd;
        f0_data_d = ex_data;
      end else begin
        f1_rd_d   = ex_rd;
        f1_data_d = ex_data;
      end
    end
    count_d = cnt_after + {1'b0, push};

    we_d    = win && (win_rd != 5'd0);
    waddr_d = we_d ? win_rd : waddr_q;
    wdata_d = we_d ? win_data : wdata_q;

    // Set after clear so a newer load to the same register stays pending.
    sb_d = sb_q;
    if (ld_valid) sb_d[ld_rd] = 1'b0;
    if (ld_issue && (ld_issue_rd != 5'd0)) sb_d[ld_issue_rd] = 1'b1;
  end

  always_comb begin
    busy_c = sb_q;
    if (count_q != 2'd0) busy_c[f0_rd_q] = 1'b1;
    if (count_q == 2'd2) busy_c[f1_rd_q] = 1'b1;
    if (we_q) busy_c[waddr_q] = 1'b1;
    busy_c[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      f0_rd_q   <= 5'd0;
      f1_rd_q   <= 5'd0;
      f0_data_q <= 64'd0;
      f1_data_q <= 64'd0;
      we_q      <= 1'b0;
      waddr_q   <= 5'd0;
      wdata_q   <= 64'd0;
      sb_q      <= 32'd0;
    end else begin
      count_q   <= count_d;
      f0_rd_q   <= f0_rd_d;
      f1_rd_q   <= f1_rd_d;
      f0_data_q <= f0_data_d;
      f1_data_q <= f1_data_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      sb_q      <= sb_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy  = busy_c;

endmodule
